// File: rtl/op_datapath_if.sv
// Bundle between the sequencing FSM / host side and the op_datapath execution unit.
// Signal names follow the FSM's existing port names.
interface op_datapath_if #(
  parameter int unsigned W  = 4,
  parameter int unsigned AW = 3
);
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [W-1:0]  ld_a;
  logic [W-1:0]  ld_b;
  logic          done;
  logic          sumen;
  logic          multien;
  logic          Consten;
  logic          erroren;
  logic          counten;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic [W-1:0]  count;
  logic [AW-1:0] rd_addr;
  logic [2*W-1:0] rd_data;
  logic [1:0]    rd_op;
  logic          result_valid;
  logic [3:0]    err_cnt;

  modport master (
    output ld_en, ld_addr, ld_a, ld_b, done,
    output sumen, multien, Consten, erroren, counten, rd_addr,
    input  A, B, count, rd_data, rd_op, result_valid, err_cnt
  );

  modport slave (
    input  ld_en, ld_addr, ld_a, ld_b, done,
    input  sumen, multien, Consten, erroren, counten, rd_addr,
    output A, B, count, rd_data, rd_op, result_valid, err_cnt
  );
endinterface

// File: rtl/op_datapath.sv
// Execution datapath behind the sequencing FSM: operand table, iteration counter,
// one op per enable pulse, and a result/op-tag log with registered readback.
module op_datapath #(
  parameter int unsigned     W         = 4,
  parameter int unsigned     DEPTH     = 8,
  parameter logic [2*W-1:0]  CONST_VAL = 8'hAA
) (
  input logic           clk,
  input logic           reset,
  op_datapath_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned RW = 2 * W;

  typedef enum logic [1:0] {
    OpSum   = 2'b00,
    OpMul   = 2'b01,
    OpConst = 2'b10,
    OpErr   = 2'b11
  } op_e;

  logic [W-1:0]  a_tab_q   [DEPTH];
  logic [W-1:0]  b_tab_q   [DEPTH];
  logic [RW-1:0] res_mem_q [DEPTH];
  logic [1:0]    op_mem_q  [DEPTH];

  logic [W-1:0]  count_q, count_d;
  logic [3:0]    err_cnt_q, err_cnt_d;
  logic [RW-1:0] rd_data_q;
  logic [1:0]    rd_op_q;
  logic          rv_q;

  logic [AW-1:0] idx;
  logic          any_op;
  op_e           op_sel;
  logic [RW-1:0] wr_data;
  logic [W:0]    sum_w;

  assign idx = count_q[AW-1:0];

  // Operands go straight to the FSM comparator with no register stage.
  assign bus.A            = a_tab_q[idx];
  assign bus.B            = b_tab_q[idx];
  assign bus.count        = count_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.rd_op        = rd_op_q;
  assign bus.result_valid = rv_q;
  assign bus.err_cnt      = err_cnt_q;

  assign any_op = bus.sumen | bus.multien | bus.Consten | bus.erroren;
  assign sum_w  = {1'b0, bus.A} + {1'b0, bus.B};

  // Enables should be one-hot; if not, the error path wins so faults are never masked.
  always_comb begin
    op_sel  = OpSum;
    wr_data = '0;
    if (bus.erroren) begin
      op_sel  = OpErr;
      wr_data = '0;
    end else if (bus.multien) begin
      op_sel  = OpMul;
      wr_data = RW'(bus.A) * RW'(bus.B);
    end else if (bus.sumen) begin
      op_sel  = OpSum;
      wr_data = RW'(sum_w);
    end else if (bus.Consten) begin
      op_sel  = OpConst;
      wr_data = CONST_VAL;
    end
  end

  always_comb begin
    count_d = count_q;
    if (bus.counten) begin
      if (count_q >= W'(DEPTH - 1)) begin
        count_d = '0;
      end else begin
        count_d = count_q + W'(1);
      end
    end
  end

  // The first op of a run (count 0) restarts the error tally.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (any_op && (count_q == '0)) begin
      err_cnt_d = {3'b000, bus.erroren};
    end else if (bus.erroren && (err_cnt_q != 4'hF)) begin
      err_cnt_d = err_cnt_q + 4'd1;
    end
  end

  // Tables are frozen while the FSM is running so A/B stay stable under evaluation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        a_tab_q[i] <= '0;
        b_tab_q[i] <= '0;
      end
    end else if (bus.ld_en && bus.done) begin
      a_tab_q[bus.ld_addr] <= bus.ld_a;
      b_tab_q[bus.ld_addr] <= bus.ld_b;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        res_mem_q[i] <= '0;
        op_mem_q[i]  <= '0;
      end
    end else if (any_op) begin
      res_mem_q[idx] <= wr_data;
      op_mem_q[idx]  <= op_sel;
    end
  end

  // Readback samples pre-write contents, so same-address read/write returns old data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q   <= '0;
      err_cnt_q <= '0;
      rd_data_q <= '0;
      rd_op_q   <= '0;
      rv_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
      rd_data_q <= res_mem_q[bus.rd_addr];
      rd_op_q   <= op_mem_q[bus.rd_addr];
      rv_q      <= any_op;
    end
  end

endmodule

// File: tb/tb_op_datapath.sv
// Directed self-checking bench for op_datapath: a cycle-by-cycle vector table
// plus hand-written sequences for reset, a full error run and run restart.
module tb_op_datapath;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  op_datapath_if #(.W(4), .AW(3)) bus ();

  op_datapath #(
    .W        (4),
    .DEPTH    (8),
    .CONST_VAL(8'hAA)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // en field order: {sumen, multien, Consten, erroren, counten}
  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] SUM  = 5'b10000;
  localparam logic [4:0] MUL  = 5'b01000;
  localparam logic [4:0] CST  = 5'b00100;
  localparam logic [4:0] ERR  = 5'b00010;
  localparam logic [4:0] CNT  = 5'b00001;

  typedef struct {
    logic       ld_en;
    logic [2:0] ld_addr;
    logic [3:0] ld_a;
    logic [3:0] ld_b;
    logic       done;
    logic [4:0] en;
    logic [2:0] rd_addr;
    logic [3:0] e_count;
    logic [3:0] e_a;
    logic [3:0] e_b;
    logic [7:0] e_rd;
    logic [1:0] e_op;
    logic       e_rv;
    logic [3:0] e_err;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] en);
    {bus.sumen, bus.multien, bus.Consten, bus.erroren, bus.counten} = en;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " count"}, 32'(bus.count), 0);
    chk({tag, " A"}, 32'(bus.A), 0);
    chk({tag, " B"}, 32'(bus.B), 0);
    chk({tag, " rd_data"}, 32'(bus.rd_data), 0);
    chk({tag, " rd_op"}, 32'(bus.rd_op), 0);
    chk({tag, " err_cnt"}, 32'(bus.err_cnt), 0);
    chk({tag, " result_valid"}, 32'(bus.result_valid), 0);
  endtask

  initial begin
    logic [3:0] ea;
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    bus.ld_en = 1'b0; bus.ld_addr = '0; bus.ld_a = '0; bus.ld_b = '0;
    bus.done = 1'b1; bus.rd_addr = '0;
    drive(NONE);
    #12;
    check_all_zero("por");
    #3 reset = 1'b1;
    cycle();

    //         ld  adr a   b   dn en    rd  cnt A   B   rd     op rv err
    vq.push_back('{1, 0, 9,  3,  1, NONE, 0, 0, 9,  3,  8'h00, 0, 0, 0});
    vq.push_back('{1, 1, 5,  5,  1, NONE, 0, 0, 9,  3,  8'h00, 0, 0, 0});
    vq.push_back('{1, 2, 15, 15, 1, NONE, 0, 0, 9,  3,  8'h00, 0, 0, 0});
    vq.push_back('{1, 5, 15, 15, 1, NONE, 0, 0, 9,  3,  8'h00, 0, 0, 0});
    vq.push_back('{0, 0, 0,  0,  0, SUM,  0, 0, 9,  3,  8'h00, 0, 1, 0});
    vq.push_back('{0, 0, 0,  0,  0, CNT,  0, 1, 5,  5,  8'h0C, 0, 0, 0});
    vq.push_back('{0, 0, 0,  0,  0, CST,  0, 1, 5,  5,  8'h0C, 0, 1, 0});
    vq.push_back('{0, 0, 0,  0,  0, CNT,  1, 2, 15, 15, 8'hAA, 2, 0, 0});
    vq.push_back('{0, 0, 0,  0,  0, MUL,  1, 2, 15, 15, 8'hAA, 2, 1, 0});
    vq.push_back('{0, 0, 0,  0,  0, CNT,  2, 3, 0,  0,  8'hE1, 1, 0, 0});
    vq.push_back('{0, 0, 0,  0,  0, CNT,  2, 4, 0,  0,  8'hE1, 1, 0, 0});
    vq.push_back('{0, 0, 0,  0,  0, CNT,  2, 5, 15, 15, 8'hE1, 1, 0, 0});
    vq.push_back('{0, 0, 0,  0,  0, SUM,  2, 5, 15, 15, 8'hE1, 1, 1, 0});
    vq.push_back('{0, 0, 0,  0,  0, NONE, 5, 5, 15, 15, 8'h1E, 0, 0, 0});
    vq.push_back('{0, 0, 0,  0,  0, CNT,  5, 6, 0,  0,  8'h1E, 0, 0, 0});
    vq.push_back('{0, 0, 0,  0,  0, CNT,  5, 7, 0,  0,  8'h1E, 0, 0, 0});
    vq.push_back('{0, 0, 0,  0,  0, CNT,  5, 0, 9,  3,  8'h1E, 0, 0, 0});
    vq.push_back('{0, 0, 0,  0,  0, CNT,  5, 1, 5,  5,  8'h1E, 0, 0, 0});
    vq.push_back('{0, 0, 0,  0,  0, CNT,  5, 2, 15, 15, 8'h1E, 0, 0, 0});
    vq.push_back('{0, 0, 0,  0,  0, CNT,  5, 3, 0,  0,  8'h1E, 0, 0, 0});
    vq.push_back('{0, 0, 0,  0,  0, CNT,  5, 4, 0,  0,  8'h1E, 0, 0, 0});
    vq.push_back('{1, 4, 7,  2,  0, NONE, 5, 4, 0,  0,  8'h1E, 0, 0, 0});
    vq.push_back('{1, 4, 7,  2,  1, NONE, 5, 4, 7,  2,  8'h1E, 0, 0, 0});
    vq.push_back('{0, 0, 0,  0,  0, SUM | MUL | CST | ERR, 4, 4, 7, 2, 8'h00, 0, 1, 1});
    vq.push_back('{0, 0, 0,  0,  0, NONE, 4, 4, 7,  2,  8'h00, 3, 0, 1});
    vq.push_back('{0, 0, 0,  0,  0, SUM | MUL, 4, 4, 7, 2, 8'h00, 3, 1, 1});
    vq.push_back('{0, 0, 0,  0,  0, NONE, 4, 4, 7,  2,  8'h0E, 1, 0, 1});

    foreach (vq[k]) begin
      bus.ld_en   = vq[k].ld_en;
      bus.ld_addr = vq[k].ld_addr;
      bus.ld_a    = vq[k].ld_a;
      bus.ld_b    = vq[k].ld_b;
      bus.done    = vq[k].done;
      bus.rd_addr = vq[k].rd_addr;
      drive(vq[k].en);
      cycle();
      chk($sformatf("vec%0d count", k), 32'(bus.count), 32'(vq[k].e_count));
      chk($sformatf("vec%0d A", k), 32'(bus.A), 32'(vq[k].e_a));
      chk($sformatf("vec%0d B", k), 32'(bus.B), 32'(vq[k].e_b));
      chk($sformatf("vec%0d rd_data", k), 32'(bus.rd_data), 32'(vq[k].e_rd));
      chk($sformatf("vec%0d rd_op", k), 32'(bus.rd_op), 32'(vq[k].e_op));
      chk($sformatf("vec%0d result_valid", k), 32'(bus.result_valid), 32'(vq[k].e_rv));
      chk($sformatf("vec%0d err_cnt", k), 32'(bus.err_cnt), 32'(vq[k].e_err));
    end
    bus.ld_en = 1'b0;
    drive(NONE);

    // Mid-cycle asynchronous reset; an enable held across an edge in reset is ignored.
    #3 reset = 1'b0;
    #1 check_all_zero("async_reset");
    drive(CNT);
    cycle();
    check_all_zero("held_reset");
    drive(NONE);
    bus.rd_addr = 3'd2;
    #4 reset = 1'b1;
    cycle();
    check_all_zero("after_reset");

    // Full run: entries 0, 3, 6 carry A=0 and are logged as errors.
    bus.done = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.ld_en   = 1'b1;
      bus.ld_addr = 3'(i);
      bus.ld_a    = (i % 3 == 0) ? 4'd0 : 4'(i + 1);
      bus.ld_b    = 4'(i);
      cycle();
    end
    bus.ld_en = 1'b0;
    bus.done  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ea = (i % 3 == 0) ? 4'd0 : 4'(i + 1);
      chk($sformatf("run it%0d count", i), 32'(bus.count), 32'(i));
      chk($sformatf("run it%0d A", i), 32'(bus.A), 32'(ea));
      drive((ea == 4'd0) ? ERR : SUM);
      cycle();
      chk($sformatf("run it%0d rv_op", i), 32'(bus.result_valid), 1);
      drive(CNT);
      cycle();
      chk($sformatf("run it%0d rv_cnt", i), 32'(bus.result_valid), 0);
    end
    drive(NONE);
    chk("run end count", 32'(bus.count), 0);
    chk("run end err_cnt", 32'(bus.err_cnt), 3);
    bus.rd_addr = 3'd3;
    cycle();
    chk("run res3 data", 32'(bus.rd_data), 0);
    chk("run res3 op", 32'(bus.rd_op), 3);
    chk("run err_cnt hold", 32'(bus.err_cnt), 3);
    bus.rd_addr = 3'd1;
    cycle();
    chk("run res1 data", 32'(bus.rd_data), 32'h03);
    chk("run res1 op", 32'(bus.rd_op), 0);

    // Second run starts without an error: tally clears on its first op.
    drive(SUM);
    cycle();
    drive(NONE);
    chk("run2 err_cnt clear", 32'(bus.err_cnt), 0);
    chk("run2 result_valid", 32'(bus.result_valid), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/op_datapath.md
# op_datapath

Execution datapath paired with the sequencing FSM, downstream of it. It consumes the FSM's one-hot enables (sumen, multien, Consten, erroren, counten) and feeds the FSM its A, B and count inputs from an 8-entry operand table. It executes one operation per enable pulse and logs each 8-bit result plus an op tag into an 8-entry result memory for readback.

## Interface

Parameters:
- W, 4: operand width; fixed by the FSM port widths.
- DEPTH, 8: number of table and result entries; matches the FSM's 8-iteration run (count 0..7).
- CONST_VAL, 8'hAA: result written on a Consten operation.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset. Low clears all state immediately.
- ld_en  in  1  operand-table write strobe. Honoured only while done=1.
- ld_addr  in  3  operand-table write index.
- ld_a  in  4  A operand to write.
- ld_b  in  4  B operand to write.
- done  in  1  FSM idle flag.
- sumen  in  1  FSM enable: execute sum.
- multien  in  1  FSM enable: execute multiply.
- Consten  in  1  FSM enable: execute constant.
- erroren  in  1  FSM enable: log an error.
- counten  in  1  FSM enable: advance count.
- A  out  4  a_tab[count[2:0]]; combinational from registers.
- B  out  4  b_tab[count[2:0]]; combinational from registers.
- count  out  4  iteration counter, driven to the FSM.
- rd_addr  in  3  result-memory read index.
- rd_data  out  8  registered result readback.
- rd_op  out  2  registered op tag readback.
- result_valid  out  1  one-cycle pulse, one cycle after each result write.
- err_cnt  out  4  saturating count of error ops in the current run.

## Operation

- **Reset values:** reset=0 clears a_tab, b_tab, res_mem, op_mem and count to 0. With count=0, A and B read as 0. rd_data, rd_op, result_valid and err_cnt also clear to 0.
- **Table load:** when ld_en=1 and done=1, write a_tab[ld_addr]<=ld_a and b_tab[ld_addr]<=ld_b. When done=0, ld_en is ignored and the tables stay frozen, so A and B are stable while the FSM evaluates them.
- **Counter:**
  - counten=1 and count>=7: count<=0.
  - counten=1 and count<7: count<=count+1.
  - Otherwise count holds.
  - Result: count never exceeds 7, and a run always starts at index 0.
- **Op select:**
  - The enables are expected one-hot.
  - If several are asserted, priority is erroren > multien > sumen > Consten.
  - Exactly one write occurs per cycle.
- **Result for the selected op** (written to idx=count[2:0]):
  - sum: res_mem[idx] <= {3'b0, A+B}, a 5-bit sum zero-extended; op_mem[idx] <= 2'b00.
  - multiply: res_mem[idx] <= A*B, full 8-bit product; op_mem[idx] <= 2'b01.
  - const: res_mem[idx] <= CONST_VAL; op_mem[idx] <= 2'b10.
  - error: res_mem[idx] <= 8'h00; op_mem[idx] <= 2'b11.
- **Error count:**
  - On any op enable with count==0, err_cnt <= (erroren ? 1 : 0). This is the start-of-run clear.
  - Otherwise erroren increments err_cnt, saturating at 15.
  - err_cnt holds between runs.
- **Readback:** rd_data <= res_mem[rd_addr] and rd_op <= op_mem[rd_addr] every cycle. A read and a write to the same address in the same cycle returns the old data.
- **result_valid:** registered copy of (any op enable), so it is high the cycle after the write.

## Timing

- **A/B/count:** zero-latency combinational paths to the FSM; they change only on clk edges (count, table) or on asynchronous reset.
- **FSM loop, per iteration:**
  - Control cycle: FSM compares A and B.
  - Op cycle: write to res_mem[count].
  - counter cycle: FSM compares the pre-increment count; count advances at the end of that cycle.
- **Run length:** a full run is 8 iterations (indices 0..7). After the last counten, count=0.
- **Write to readback latency:**
  - Result write at edge N.
  - result_valid is high during cycle N+1.
  - rd_data reflects the new value one edge after rd_addr is presented, from edge N+1 onward.
- **Reset mid-run:**
  - Asserting reset asynchronously clears count and the memories.
  - Enables arriving in the same cycle as reset release are ignored if reset is still low at the edge.
  - The FSM must be reset with the same signal.

## Test plan

1. **Reset:** pulse reset low mid-cycle → count=0, A=B=0, rd_data=0, rd_op=0, err_cnt=0, result_valid=0 immediately; preloaded tables read back as 0.
2. **Sum and const:** load entry0 A=9, B=3 and entry1 A=5, B=5. Pulse sumen at count=0, then counten, then Consten at count=1 → res_mem[0]=8'h0C/op 00, res_mem[1]=8'hAA/op 10; result_valid high one cycle after each write.
3. **Multiply width:** entry2 A=15, B=15, multien at count=2 → rd_data=8'hE1, rd_op=01. Sum 15+15 at another index → 8'h1E (no truncation).
4. **Errors and err_cnt:**
   - Full 8-iteration run with entries 0, 3, 6 having A=0 (erroren there) → err_cnt=3 and res_mem[3]=0/op 11.
   - Start a second run with no errors → err_cnt=0 after its first op.
5. **Counter wrap:** 8 counten pulses from 0 → count sequence 1..7, then 0. A and B track table[count] each cycle.
6. **Load gating:** ld_en with ld_addr=4 while done=0 → table unchanged; same load with done=1 → A shows the new value when count=4.
